// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter for the shared data-memory / I/O bus.
// Grants one single-word transfer at a time; the CPU wins the first tie.
module dmem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_datain,
  output logic        bus_we,
  input  logic [31:0] bus_dataout,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               NO_WAIT = (WAIT_CYCLES == 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic             last_q;
  logic             owner_q;
  logic             busy_q;
  logic             bus_we_q;
  logic             cpu_ack_q;
  logic             dma_ack_q;
  logic [31:0]      bus_addr_q;
  logic [31:0]      bus_data_q;
  logic [31:0]      cpu_rdata_q;
  logic [31:0]      dma_rdata_q;

  logic gnt_dma;
  logic enter_done;

  // last_q=1 means DMA was served last, so a tie goes to the CPU
  assign gnt_dma = dma_req & (~cpu_req | ~last_q);

  assign enter_done =
    (state_q == S_ISSUE && NO_WAIT) ||
    (state_q == S_WAIT && cnt_q == CNT_ONE);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      bus_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      bus_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cpu_req | dma_req) begin
            owner_q    <= gnt_dma;
            we_q       <= gnt_dma ? dma_we : cpu_we;
            bus_we_q   <= gnt_dma ? dma_we : cpu_we;
            bus_addr_q <= gnt_dma ? dma_addr : cpu_addr;
            bus_data_q <= gnt_dma ? dma_wdata : cpu_wdata;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (NO_WAIT) begin
            state_q <= S_DONE;
          end else begin
            cnt_q   <= WAIT_LD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
      // read data lands with the ack so the winner can use it in DONE
      if (enter_done) begin
        if (owner_q) dma_ack_q <= 1'b1;
        else         cpu_ack_q <= 1'b1;
        if (!we_q) begin
          if (owner_q) dma_rdata_q <= bus_dataout;
          else         cpu_rdata_q <= bus_dataout;
        end
      end
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign dma_ack    = dma_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign bus_addr   = bus_addr_q;
  assign bus_datain = bus_data_q;
  assign bus_we     = bus_we_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: random rounds on a zero-wait
// instance plus directed timing/reset cases on a three-wait instance.
module tb_dmem_bus_arbiter;

  localparam int W3 = 3;

  logic clock = 1'b0;
  logic clrn  = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // zero-wait instance
  logic        cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dma_req = 0, dma_we = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic [31:0] bus_addr, bus_datain, bus_dataout;
  logic        bus_we, busy, owner;

  // three-wait instance
  logic        w_cpu_req = 0, w_cpu_we = 0;
  logic [31:0] w_cpu_addr = 0, w_cpu_wdata = 0;
  logic        w_cpu_ack;
  logic [31:0] w_cpu_rdata;
  logic        w_dma_req = 0, w_dma_we = 0;
  logic [31:0] w_dma_addr = 0, w_dma_wdata = 0;
  logic        w_dma_ack;
  logic [31:0] w_dma_rdata;
  logic [31:0] w_bus_addr, w_bus_datain, w_bus_dataout;
  logic        w_bus_we, w_busy, w_owner;

  dmem_bus_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) u0 (
    .clock(clock), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .bus_addr(bus_addr), .bus_datain(bus_datain),
    .bus_we(bus_we), .bus_dataout(bus_dataout),
    .busy(busy), .owner(owner)
  );

  dmem_bus_arbiter #(.WAIT_CYCLES(W3), .CNT_W(4)) u3 (
    .clock(clock), .clrn(clrn),
    .cpu_req(w_cpu_req), .cpu_we(w_cpu_we),
    .cpu_addr(w_cpu_addr), .cpu_wdata(w_cpu_wdata),
    .cpu_ack(w_cpu_ack), .cpu_rdata(w_cpu_rdata),
    .dma_req(w_dma_req), .dma_we(w_dma_we),
    .dma_addr(w_dma_addr), .dma_wdata(w_dma_wdata),
    .dma_ack(w_dma_ack), .dma_rdata(w_dma_rdata),
    .bus_addr(w_bus_addr), .bus_datain(w_bus_datain),
    .bus_we(w_bus_we), .bus_dataout(w_bus_dataout),
    .busy(w_busy), .owner(w_owner)
  );

  function automatic logic [31:0] memv(int i);
    return (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i * 7);
  endfunction

  // bus-side memory for the zero-wait instance
  logic [31:0] mem [64];
  always @(posedge clock) begin
    if (!clrn) begin
      for (int i = 0; i < 64; i++) mem[i] <= memv(i);
    end else if (bus_we) begin
      mem[bus_addr[7:2]] <= bus_datain;
    end
  end
  assign bus_dataout   = mem[bus_addr[7:2]];
  assign w_bus_dataout = ~w_bus_addr;

  int total = 0;
  int bad   = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // transaction-level reference: grant order, memory image, rdata
  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          acyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [64];
  logic [31:0] mr [2];
  bit          mlast;
  bit          mon_on = 0;

  task automatic push(bit m, bit we, logic [31:0] a,
                      logic [31:0] wd, int acyc);
    exp_t e;
    if (we) mm[a[7:2]] = wd;
    else    mr[m] = mm[a[7:2]];
    e.m = m; e.we = we; e.addr = a; e.wdata = wd;
    e.rdata = mr[m]; e.acyc = acyc;
    mlast = m;
    q.push_back(e);
  endtask

  exp_t mon_e;
  int   we_cnt = 0;

  always @(negedge clock) begin
    if (clrn && mon_on) begin
      if (bus_we) begin
        we_cnt++;
        if (q.size() > 0) begin
          check("wr_addr", bus_addr, q[0].addr);
          check("wr_data", bus_datain, q[0].wdata);
        end
      end
      if (cpu_ack || dma_ack) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got cpu=%0d dma=%0d want none",
                   cpu_ack, dma_ack);
        end else begin
          mon_e = q.pop_front();
          check("ack_owner", 32'(owner), 32'(mon_e.m));
          check("ack_line", {30'd0, cpu_ack, dma_ack},
                mon_e.m ? 32'd1 : 32'd2);
          check("ack_cycle", cyc, mon_e.acyc);
          check("ack_addr", bus_addr, mon_e.addr);
          check("we_cycles", we_cnt, 32'(mon_e.we));
          check("rdata", mon_e.m ? dma_rdata : cpu_rdata, mon_e.rdata);
        end
        we_cnt = 0;
      end
    end
  end

  task automatic wait_ack(bit m);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      seen = m ? dma_ack : cpu_ack;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_timeout: master %0d got no ack want ack", m);
    end
    if (m) begin dma_req = 0; dma_addr = $urandom; end
    else   begin cpu_req = 0; cpu_addr = $urandom; end
  endtask

  task automatic round(bit c, bit d,
                       bit cw, logic [31:0] ca, logic [31:0] cd,
                       bit dw, logic [31:0] da, logic [31:0] dd);
    bit first;
    int k;
    @(negedge clock);
    k = cyc;
    first = (c && d) ? ~mlast : d;
    if (!first) begin
      push(0, cw, ca, cd, k + 2);
      if (d) push(1, dw, da, dd, k + 5);
    end else begin
      push(1, dw, da, dd, k + 2);
      if (c) push(0, cw, ca, cd, k + 5);
    end
    cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; cpu_req = c;
    dma_we = dw; dma_addr = da; dma_wdata = dd; dma_req = d;
    fork
      begin if (c) wait_ack(0); end
      begin if (d) wait_ack(1); end
    join
  endtask

  task automatic stream6();
    bit first;
    int k;
    int n = 0;
    @(negedge clock);
    k = cyc;
    first = ~mlast;
    for (int i = 0; i < 6; i++) begin
      if ((i % 2 == 0) ? first : ~first)
        push(1, 1, 32'h0000_0024, 32'h0000_5A5A, k + 2 + 3 * i);
      else
        push(0, 0, 32'h0000_0020, 32'h0, k + 2 + 3 * i);
    end
    cpu_we = 0; cpu_addr = 32'h20; cpu_req = 1;
    dma_we = 1; dma_addr = 32'h24; dma_wdata = 32'h5A5A; dma_req = 1;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clock);
      if (cpu_ack || dma_ack) n++;
    end
    cpu_req = 0; dma_req = 0;
    check("stream_acks", n, 6);
  endtask

  // three-wait instance: single CPU read, optional early req drop
  task automatic w_read(logic [31:0] a, bit drop, bit move_addr);
    int k;
    int lat = -1;
    int wec = 0;
    @(negedge clock);
    w_cpu_we = 0; w_cpu_addr = a; w_cpu_req = 1;
    k = cyc;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clock);
      if (w_bus_we) wec++;
      if (w_dma_ack) wec += 100;
      if (i == 1) begin
        check("w_issue_addr", w_bus_addr, a);
        check("w_issue_busy", 32'(w_busy), 32'd1);
        if (drop) w_cpu_req = 0;
      end
      if (i == 2 && move_addr) w_cpu_addr = a ^ 32'h0000_0F00;
      if (w_cpu_ack) lat = cyc - k;
    end
    w_cpu_req = 0;
    check("w_latency", lat, 2 + W3);
    check("w_rdata", w_cpu_rdata, ~a);
    check("w_ack_addr", w_bus_addr, a);
    check("w_no_we", wec, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin : main
    int k;
    int lat;
    for (int i = 0; i < 64; i++) mm[i] = memv(i);
    mr[0] = 0; mr[1] = 0;
    mlast = 1;
    clrn = 0;
    repeat (3) @(negedge clock);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_datain", bus_datain, 0);
    check("rst_ctl", {26'd0, bus_we, busy, owner, cpu_ack, dma_ack, 1'b0}, 0);
    check("rst_rdata", cpu_rdata | dma_rdata, 0);
    check("rst_w_ctl", {27'd0, w_bus_we, w_busy, w_owner, w_cpu_ack, w_dma_ack}, 0);
    clrn = 1;
    mon_on = 1;

    round(1, 0, 0, 32'h0000_0010, 32'h0, 0, 32'h0, 32'h0);
    check("cpu_read_rdata", cpu_rdata, 32'hDEAD_BEEF);
    round(0, 1, 0, 32'h0, 32'h0, 1, 32'h0000_0080, 32'h0000_00A5);
    check("dma_write_rdata", dma_rdata, 0);
    stream6();

    for (int r = 0; r < 40; r++) begin
      int pat;
      pat = $urandom_range(1, 3);
      round(pat[0], pat[1],
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
    end
    repeat (3) @(negedge clock);
    check("sb_drained", q.size(), 0);
    check("idle_busy", 32'(busy), 0);
    mon_on = 0;

    w_read(32'h0000_0040, 0, 1);
    w_read(32'h0000_0044, 1, 0);
    repeat (2) @(negedge clock);
    check("w_drop_idle", 32'(w_busy), 0);
    check("w_drop_noack", 32'(w_cpu_ack), 0);

    @(negedge clock);
    w_dma_we = 1; w_dma_addr = 32'h80; w_dma_wdata = 32'h5; w_dma_req = 1;
    @(negedge clock);
    check("w_dma_issue_we", 32'(w_bus_we), 1);
    @(negedge clock);
    check("w_dma_wait_busy", 32'(w_busy), 1);
    clrn = 0;
    #1;
    check("w_rst_we", 32'(w_bus_we), 0);
    check("w_rst_busy", 32'(w_busy), 0);
    check("w_rst_acks", {30'd0, w_cpu_ack, w_dma_ack}, 0);
    check("w_rst_rdata", w_cpu_rdata | w_dma_rdata, 0);
    check("w_rst_addr", w_bus_addr, 0);
    w_dma_req = 0;
    @(negedge clock);
    clrn = 1;
    mlast = 1; mr[0] = 0; mr[1] = 0;

    @(negedge clock);
    w_cpu_we = 0; w_cpu_addr = 32'h48; w_cpu_req = 1;
    w_dma_we = 0; w_dma_addr = 32'h4C; w_dma_req = 1;
    k = cyc;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clock);
      if (w_cpu_ack || w_dma_ack) lat = cyc - k;
    end
    check("tie_latency", lat, 2 + W3);
    check("tie_acks", {30'd0, w_cpu_ack, w_dma_ack}, 2);
    check("tie_owner", 32'(w_owner), 0);
    check("tie_rdata", w_cpu_rdata, ~32'h48);
    w_cpu_req = 0;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clock);
      if (w_dma_ack) lat = cyc - k;
    end
    w_dma_req = 0;
    check("tie2_latency", lat, 5 + 2 * W3);
    check("tie2_rdata", w_dma_rdata, ~32'h4C);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
